// File: rtl/hash_light_msg_ctrl_pkg.sv
// hash_light_pkg: shared types, constants and block packer for the light-hash message controller
package hash_light_pkg;
  localparam int BLOCK_BYTES = 4;
  typedef logic [7:0] byte_t;
  typedef byte_t [0:BLOCK_BYTES-1] block_t;
  typedef enum logic [2:0] {IDLE, COLLECT, START, WAIT, OUT} msg_state_e;
  localparam byte_t PAD_BYTE = 8'h80;
  function automatic block_t pack_byte(block_t b, logic [1:0] idx, byte_t d, logic last);
    block_t r;
    for (int i = 0; i < BLOCK_BYTES; i++)
      r[i] = i == int'(idx) ? d : last && i > int'(idx) ? (i == int'(idx) + 1 ? PAD_BYTE : 8'h00) : b[i];
    return r;
  endfunction
endpackage

// File: rtl/hash_light_msg_ctrl_if.sv
// hash_light_msg_ctrl_if: upstream byte stream (in_valid/in_ready/in_data/in_last); master = source, slave = controller
interface hash_light_msg_ctrl_if;
  import hash_light_pkg::*;
  logic in_valid;
  logic in_ready;
  logic in_last;
  byte_t in_data;
  modport master(output in_valid, in_data, in_last, input in_ready);
  modport slave(input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/hash_light_msg_ctrl.sv
// hash_light_msg_ctrl: packs a byte stream into padded 4-byte blocks, drives hash core start/m/iv, chains d, emits dig_valid/dig_data, err on done timeout
module hash_light_msg_ctrl
  import hash_light_pkg::*;
#(
  parameter block_t IV_INIT = 32'h34550F14,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  hash_light_msg_ctrl_if.slave up,
  output logic hash_start,
  output block_t hash_m,
  output block_t hash_iv,
  input  block_t hash_d,
  input  logic hash_done,
  output logic dig_valid,
  output block_t dig_data,
  output logic err
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  msg_state_e state, nxt;
  logic [1:0] idx;
  logic last_flag, pad_pending;
  logic [CW-1:0] cnt;
  block_t chain;
  logic acc, blk_end, done_ok, tmo;
  assign up.in_ready = state == IDLE || state == COLLECT;
  assign hash_iv = chain;
  always_comb begin
    acc = up.in_valid && up.in_ready;
    blk_end = acc && (idx == 2'd3 || up.in_last);
    done_ok = state == WAIT && cnt != '0 && hash_done;
    tmo = state == WAIT && !done_ok && cnt == CNT_LAST;
    hash_start = state == START;
    err = tmo;
    nxt = state;
    case (state)
      IDLE, COLLECT: nxt = blk_end ? START : acc ? COLLECT : state;
      START: nxt = WAIT;
      WAIT: nxt = done_ok ? (pad_pending ? START : last_flag ? OUT : COLLECT) : tmo ? IDLE : WAIT;
      OUT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      last_flag <= 1'b0;
      pad_pending <= 1'b0;
      cnt <= '0;
      chain <= IV_INIT;
      hash_m <= '0;
      dig_valid <= 1'b0;
      dig_data <= '0;
    end else begin
      state <= nxt;
      dig_valid <= state == OUT;
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (acc) begin
        hash_m <= pack_byte(hash_m, idx, up.in_data, up.in_last);
        idx <= idx + 1'b1;
      end else if (!up.in_ready) idx <= '0;
      if (blk_end) begin
        last_flag <= up.in_last;
        pad_pending <= up.in_last && idx == 2'd3;
      end
      if (done_ok && pad_pending) begin
        hash_m <= {PAD_BYTE, 8'h00, 8'h00, 8'h00};
        pad_pending <= 1'b0;
      end
      chain <= done_ok ? hash_d : (state == IDLE || state == OUT || tmo) ? IV_INIT : chain;
      if (state == OUT) dig_data <= chain;
    end
  end
endmodule

// File: tb/tb_hash_light_msg_ctrl.sv
// tb_hash_light_msg_ctrl: directed bench with stub xor core and a padding/chaining reference model
module tb_hash_light_msg_ctrl;
  import hash_light_pkg::*;
  localparam block_t IV = 32'h34550F14;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  hash_light_msg_ctrl_if up();
  logic hash_start, hash_done, dig_valid, err;
  block_t hash_m, hash_iv, hash_d, dig_data;
  hash_light_msg_ctrl #(.IV_INIT(IV), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .up(up), .hash_start(hash_start), .hash_m(hash_m), .hash_iv(hash_iv),
    .hash_d(hash_d), .hash_done(hash_done), .dig_valid(dig_valid), .dig_data(dig_data), .err(err)
  );
  int since = 100;
  bit stale_mode = 0;
  bit nodone = 0;
  block_t stub_d = '0;
  always @(posedge clk) begin
    if (hash_start) since <= 0;
    else begin
      since <= since + 1;
      if (since == 1) stub_d <= hash_m ^ hash_iv;
    end
  end
  assign hash_d = stub_d;
  assign hash_done = !nodone && (since >= 2 || (stale_mode && since == 0));
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_start = -100;
  int prev_start = -100;
  int hs_cyc = 0;
  int exp_err = 0;
  block_t cur_m = '0;
  logic [63:0] exp_blk[$];
  block_t exp_dig[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_msg(input logic [7:0] msg[$], input bit want, output block_t dig);
    logic [7:0] p[$];
    block_t iv, m;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 4 != 0) p.push_back(8'h00);
    iv = IV;
    for (int b = 0; b < p.size() / 4; b++) begin
      m = {p[4*b], p[4*b+1], p[4*b+2], p[4*b+3]};
      exp_blk.push_back({m, iv});
      iv = m ^ iv;
    end
    if (want) exp_dig.push_back(iv);
    dig = iv;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (hash_start) begin
        prev_start = last_start;
        last_start = cyc;
        cur_m = hash_m;
        if (exp_blk.size() == 0) chk("start_without_block", 64'(hash_start), 64'd0);
        else chk("block_m_iv", {hash_m, hash_iv}, exp_blk.pop_front());
      end else if (!up.in_ready) chk("m_stable", 64'(hash_m), 64'(cur_m));
      if (dig_valid) begin
        if (exp_dig.size() == 0) chk("dig_without_msg", 64'(dig_valid), 64'd0);
        else begin
          chk("digest", 64'(dig_data), 64'(exp_dig.pop_front()));
          chk("dig_latency", 64'(cyc - last_start), 64'd5);
        end
      end
      if (err) begin
        if (exp_err == 0) chk("err_unexpected", 64'(err), 64'd0);
        else begin
          exp_err--;
          chk("err_latency", 64'(cyc - last_start), 64'd16);
        end
      end
    end
  end
  task automatic send(input logic [7:0] msg[$], input bit hold);
    for (int i = 0; i < msg.size(); i++) begin
      int n;
      n = 0;
      up.in_valid = 1;
      up.in_data = msg[i];
      up.in_last = i == msg.size() - 1;
      @(negedge clk);
      while (!up.in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chk("byte_accept_timeout", 64'(up.in_ready), 64'd1);
      hs_cyc = cyc;
      @(posedge clk);
      #1;
    end
    if (!hold) begin
      up.in_valid = 0;
      up.in_last = 0;
    end
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_blk.size() != 0 || exp_dig.size() != 0 || exp_err != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_blk.size() + exp_dig.size() + exp_err), 64'd0);
    @(posedge clk);
    #1;
  endtask
  logic [7:0] c1[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] c2[$] = '{8'hAA, 8'hBB};
  logic [7:0] c6[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] c8[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    block_t d;
    int hs, n;
    up.in_valid = 0;
    up.in_data = 0;
    up.in_last = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(up.in_ready), 64'd1);
    chk("rst_hash_start", 64'(hash_start), 64'd0);
    chk("rst_hash_m", 64'(hash_m), 64'd0);
    chk("rst_hash_iv", 64'(hash_iv), 64'(IV));
    chk("rst_dig", {31'd0, dig_valid, dig_data}, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 0;
    model_msg(c1, 1, d);
    chk("model_c1", 64'(d), 64'hB5570C10);
    chk("model_c1_pad", exp_blk[exp_blk.size()-1], 64'h80000000_35570C10);
    send(c1, 0);
    wait_done();
    chk("dut_c1", 64'(dig_data), 64'hB5570C10);
    chk("pad_start_gap", 64'(last_start - prev_start), 64'd4);
    model_msg(c2, 1, d);
    chk("model_c2", 64'(d), 64'h9EEE8F14);
    send(c2, 0);
    hs = hs_cyc;
    wait_done();
    chk("start_after_byte", 64'(last_start - hs), 64'd1);
    chk("dut_c2", 64'(dig_data), 64'h9EEE8F14);
    stale_mode = 1;
    model_msg(c2, 1, d);
    model_msg(c2, 1, d);
    send(c2, 0);
    send(c2, 0);
    wait_done();
    chk("dut_stale", 64'(dig_data), 64'h9EEE8F14);
    stale_mode = 0;
    model_msg(c1, 1, d);
    send(c1, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("midrst_in_ready", 64'(up.in_ready), 64'd1);
    chk("midrst_iv", 64'(hash_iv), 64'(IV));
    chk("midrst_quiet", {62'd0, dig_valid, err}, 64'd0);
    exp_blk.delete();
    exp_dig.delete();
    repeat (10) @(posedge clk);
    #1;
    model_msg(c2, 1, d);
    send(c2, 0);
    wait_done();
    chk("dut_after_rst", 64'(dig_data), 64'h9EEE8F14);
    model_msg(c1, 1, d);
    model_msg(c2, 1, d);
    model_msg(c8, 1, d);
    chk("model_c8", 64'(d), 64'hB0510B18);
    send(c1, 1);
    send(c2, 1);
    send(c8, 0);
    wait_done();
    chk("dut_held_valid", 64'(dig_data), 64'hB0510B18);
    model_msg(c6, 0, d);
    chk("model_c6_blk2", exp_blk[1], 64'h55668000_25773C50);
    exp_err = 1;
    send(c6, 0);
    nodone = 1;
    n = 0;
    while (exp_err != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("err_seen", 64'(exp_err), 64'd0);
    @(negedge clk);
    chk("tmo_in_ready", 64'(up.in_ready), 64'd1);
    chk("tmo_iv", 64'(hash_iv), 64'(IV));
    nodone = 0;
    wait_done();
    model_msg(c2, 1, d);
    send(c2, 0);
    wait_done();
    chk("dut_after_tmo", 64'(dig_data), 64'h9EEE8F14);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
